// File: rtl/net_array_renderer_pkg.sv
// Shared game definitions: video geometry and the net drawing mode encodings.
package net_array_renderer_pkg;

  // Active video area of the game screen.
  localparam int H_VIDEO = 640;
  localparam int V_VIDEO = 480;

  // Width of the pixel coordinate buses coming from the sync generator.
  localparam int COORD_W = 10;

  // Net drawing modes as seen on the mode input.
  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STATIC = 2'b01,
    MODE_SCROLL = 2'b10,
    MODE_SOLID  = 2'b11
  } net_mode_e;

endpackage

// File: rtl/net_array_renderer_dash_phase_counter.sv
// Modulo-PERIOD row counter for the dash pattern. next_value is the value the
// counter takes on this edge, so the pixel path can use it in the same cycle.
module dash_phase_counter #(
  parameter int PERIOD = 24,
  parameter int START  = 18,
  localparam int CW    = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          inc,
  output logic [CW-1:0] value,
  output logic [CW-1:0] next_value
);
  import net_array_renderer_pkg::*;

  // Load takes priority over increment; increment wraps PERIOD-1 back to 0.
  always_comb begin
    next_value = value;
    if (load)
      next_value = load_val;
    else if (inc)
      next_value = (value == CW'(PERIOD - 1)) ? '0 : value + CW'(1);
  end

  // Count register, reset to the start phase.
  always_ff @(posedge clk) begin
    if (rst)
      value <= CW'(START);
    else
      value <= next_value;
  end

endmodule

// File: rtl/net_array_renderer.sv
// Draws NUM_NETS vertical dashed/solid net columns. The dash pattern can be
// static or scroll downward by SCROLL_STEP rows per frame. Output is registered.
module net_array_renderer #(
  parameter int H_VIDEO     = net_array_renderer_pkg::H_VIDEO,
  parameter int NET_WIDTH   = 6,
  parameter int DASH_HEIGHT = 12,
  parameter int GAP_HEIGHT  = 12,
  parameter int NUM_NETS    = 1,
  parameter int START_PHASE = 18,
  parameter int SCROLL_STEP = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [net_array_renderer_pkg::COORD_W-1:0]  pixel_x,
  input  logic [net_array_renderer_pkg::COORD_W-1:0]  pixel_y,
  input  logic                                        video_on,
  input  logic [1:0]                                  mode,
  output logic                                        pixel_on,
  output logic                                        frame_tick
);
  import net_array_renderer_pkg::*;

  localparam int PERIOD = DASH_HEIGHT + GAP_HEIGHT;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int HALF   = NET_WIDTH / 2;

  net_mode_e     mode_q;
  net_mode_e     mode_in;
  net_mode_e     mode_eff;
  logic [CW-1:0] frame_phase;
  logic [CW-1:0] phase_next;
  logic [CW-1:0] row_q;
  logic [CW-1:0] row_cur;
  logic          frame_start;
  logic          line_start;
  logic          lit;
  logic [NUM_NETS-1:0] net_hit;

  assign mode_in     = net_mode_e'(mode);
  assign frame_start = video_on && (pixel_x == '0) && (pixel_y == '0);
  assign line_start  = video_on && (pixel_x == '0) && (pixel_y != '0);

  // The mode for the frame starting this cycle is the one being latched now,
  // so the first row of a frame already renders with the new mode.
  assign mode_eff = frame_start ? mode_in : mode_q;

  // Phase for the frame about to start: scrolling moves the pattern down,
  // i.e. the phase steps backward with wrap. Sum stays below PERIOD.
  always_comb begin
    phase_next = frame_phase;
    if (mode_q == MODE_SCROLL) begin
      if (frame_phase >= CW'(SCROLL_STEP))
        phase_next = frame_phase - CW'(SCROLL_STEP);
      else
        phase_next = frame_phase + CW'(PERIOD - SCROLL_STEP);
    end
  end

  // Frame-rate state: latched mode and pattern phase, both updated only at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_OFF;
      frame_phase <= CW'(START_PHASE);
    end else if (frame_start) begin
      mode_q      <= mode_in;
      frame_phase <= phase_next;
    end
  end

  // Row-in-period counter: loads the frame phase at frame start, steps each line.
  dash_phase_counter #(
    .PERIOD (PERIOD),
    .START  (START_PHASE)
  ) u_row_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (frame_start),
    .load_val   (phase_next),
    .inc        (line_start),
    .value      (row_q),
    .next_value (row_cur)
  );

  // Column decode per net; overlapping columns simply OR together.
  for (genvar k = 0; k < NUM_NETS; k++) begin : g_net
    localparam int CTR = H_VIDEO * (k + 1) / (NUM_NETS + 1);
    localparam int LO  = CTR - HALF;
    localparam int HI  = CTR + HALF - 1;
    assign net_hit[k] = (int'(pixel_x) >= LO) && (int'(pixel_x) <= HI);
  end

  // Row lighting for the active mode: dashes use the row-in-period value.
  always_comb begin
    lit = 1'b0;
    case (mode_eff)
      MODE_STATIC, MODE_SCROLL: lit = (row_cur < CW'(DASH_HEIGHT));
      MODE_SOLID:               lit = 1'b1;
      default:                  lit = 1'b0;
    endcase
  end

  // Registered outputs: pixel one cycle after its coordinates, tick after frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_on   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pixel_on   <= video_on && (|net_hit) && lit;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_net_array_renderer.sv
// Bench for net_array_renderer: default 1-net instance and a 3-net instance
// share stimulus; a frame-level reference model predicts every pixel.
module tb_net_array_renderer;

  localparam int P     = 24;
  localparam int DASH  = 12;
  localparam int START = 18;
  localparam int STEP  = 1;
  localparam int W     = 6;
  localparam int H     = 640;

  logic       clk = 1'b0;
  logic       rst;
  logic       video_on;
  logic [9:0] px;
  logic [9:0] py;
  logic [1:0] mode;
  logic       pix0, tick0, pix1, tick1;

  always #5 clk = ~clk;

  net_array_renderer dut0 (
    .clk(clk), .rst(rst), .pixel_x(px), .pixel_y(py), .video_on(video_on),
    .mode(mode), .pixel_on(pix0), .frame_tick(tick0)
  );

  net_array_renderer #(.NUM_NETS(3)) dut1 (
    .clk(clk), .rst(rst), .pixel_x(px), .pixel_y(py), .video_on(video_on),
    .mode(mode), .pixel_on(pix1), .frame_tick(tick1)
  );

  int total = 0;
  int bad   = 0;
  int m_mode  = 0;
  int m_phase = START;
  int tick_cnt = 0;
  int cols[$];

  typedef struct {
    int y;
    int x;
    bit exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic bit in_net(input int nets, input int x);
    bit hit = 0;
    for (int k = 0; k < nets; k++) begin
      int c = H * (k + 1) / (nets + 1);
      if (x >= c - W / 2 && x <= c + W / 2 - 1) hit = 1;
    end
    return hit;
  endfunction

  // Pixel is lit when on a net and the frame's mode lights this row.
  function automatic bit model_pix(input int nets, input bit v, input int x, input int y);
    bit row_lit;
    row_lit = (m_mode == 3) || ((m_mode == 1 || m_mode == 2) && ((m_phase + y) % P) < DASH);
    return v && in_net(nets, x) && row_lit;
  endfunction

  task automatic step(input bit r, input bit v, input int x, input int y, input int m);
    bit e0, e1, et;
    rst = r; video_on = v; px = 10'(x); py = 10'(y); mode = 2'(m);
    if (r) begin
      m_mode = 0; m_phase = START; e0 = 0; e1 = 0; et = 0;
    end else begin
      et = v && x == 0 && y == 0;
      if (et) begin
        if (m_mode == 2) m_phase = (m_phase - STEP + P) % P;
        m_mode = m;
      end
      e0 = model_pix(1, v, x, y);
      e1 = model_pix(3, v, x, y);
    end
    @(posedge clk); #1;
    check($sformatf("pix1net x=%0d y=%0d", x, y), int'(pix0), int'(e0));
    check($sformatf("pix3net x=%0d y=%0d", x, y), int'(pix1), int'(e1));
    check("tick1net", int'(tick0), int'(et));
    check("tick3net", int'(tick1), int'(et));
    if (tick0) tick_cnt++;
  endtask

  // One frame of sparse scanning: line start, net edges, random columns,
  // in-line blanking at x=0, then vertical blanking. Reports first lit row at x=320.
  task automatic run_frame(input int m, input int nrows, input int chg_row, input int chg_m,
                           input int rst_row, output int first_lit, output int ticks);
    int cm = m;
    int t0 = tick_cnt;
    first_lit = -1;
    for (int y = 0; y < nrows; y++) begin
      if (y == chg_row) cm = chg_m;
      if (y == rst_row) step(1, 1, 320, y, cm);
      step(0, 1, 0, y, cm);
      foreach (cols[i]) begin
        step(0, 1, cols[i], y, cm);
        if (cols[i] == 320 && pix0 && first_lit < 0) first_lit = y;
      end
      for (int j = 0; j < 2; j++) step(0, 1, int'($urandom_range(1, 639)), y, cm);
      step(0, 0, 0, y, cm);
      step(0, 0, int'($urandom_range(1, 639)), y, cm);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, nrows + k, cm);
    step(0, 0, 0, 0, cm);
    ticks = tick_cnt - t0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int fl, tk, cur_y;
    cols = '{316, 317, 320, 322, 323, 156, 157, 162, 163, 476, 477, 482, 483};
    tbl.push_back('{0, 320, 1'b0});
    tbl.push_back('{5, 317, 1'b0});
    tbl.push_back('{6, 317, 1'b1});
    tbl.push_back('{6, 322, 1'b1});
    tbl.push_back('{6, 316, 1'b0});
    tbl.push_back('{6, 323, 1'b0});
    tbl.push_back('{17, 320, 1'b1});
    tbl.push_back('{18, 320, 1'b0});
    tbl.push_back('{29, 322, 1'b0});
    tbl.push_back('{30, 317, 1'b1});
    tbl.push_back('{41, 322, 1'b1});
    tbl.push_back('{42, 320, 1'b0});
    tbl.push_back('{47, 319, 1'b0});

    // Reset overrides a frame-start pattern in solid mode.
    step(1, 1, 0, 0, 3);
    step(1, 1, 320, 0, 3);

    // Static frame from table vectors.
    step(0, 1, 0, 0, 1);
    cur_y = 0;
    foreach (tbl[i]) begin
      while (cur_y < tbl[i].y) begin
        cur_y++;
        step(0, 1, 0, cur_y, 1);
      end
      step(0, 1, tbl[i].x, cur_y, 1);
      check($sformatf("vec%0d", i), int'(pix0), int'(tbl[i].exp));
    end

    run_frame(1, 48, -1, 0, -1, fl, tk);
    check("static_first", fl, 6);
    check("static_ticks", tk, 1);

    run_frame(3, 48, -1, 0, -1, fl, tk);
    check("solid_first", fl, 0);

    // Mode dropped to off mid-frame: current frame keeps dashes, next is dark.
    run_frame(1, 120, 100, 0, -1, fl, tk);
    check("midchg_first", fl, 6);
    check("midchg_ticks", tk, 1);
    run_frame(0, 48, -1, 0, -1, fl, tk);
    check("off_first", fl, -1);
    check("off_ticks", tk, 1);

    // Reset mid-frame at row 200, then phase back at start value.
    run_frame(1, 210, -1, 0, 200, fl, tk);
    check("rstmid_first", fl, 6);
    run_frame(1, 48, -1, 0, -1, fl, tk);
    check("postrst_first", fl, 6);

    // Scrolling: first lit row advances one row per frame, wraps after 24.
    for (int f = 1; f <= 25; f++) begin
      run_frame(2, 48, -1, 0, -1, fl, tk);
      check($sformatf("scroll_ticks f%0d", f), tk, 1);
      case (f)
        1:  check("scroll_f1", fl, 6);
        2:  check("scroll_f2", fl, 7);
        3:  check("scroll_f3", fl, 8);
        4:  check("scroll_f4", fl, 9);
        25: check("scroll_f25", fl, 6);
        default: ;
      endcase
    end

    // Random frames with random mid-frame mode changes.
    for (int i = 0; i < 6; i++) begin
      int rm = int'($urandom_range(0, 3));
      int nr = int'($urandom_range(24, 60));
      int cr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, nr - 1)) : -1;
      run_frame(rm, nr, cr, int'($urandom_range(0, 3)), -1, fl, tk);
      check($sformatf("rand_ticks %0d", i), tk, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/net_array_renderer.md
NET_ARRAY_RENDERER -- requirements
Module: net_array_renderer

Interface
REQ-001 Parameter H_VIDEO, default 640: active pixels per line.
REQ-002 Parameter NET_WIDTH, default 6: net column width in pixels, even, 2..16.
REQ-003 Parameter DASH_HEIGHT, default 12: lit rows per period, >=1.
REQ-004 Parameter GAP_HEIGHT, default 12: dark rows per period, >=1; DASH_HEIGHT+GAP_HEIGHT (PERIOD) <= 64.
REQ-005 Parameter NUM_NETS, default 1: vertical nets drawn, 1..4.
REQ-006 Parameter START_PHASE, default 18: phase at reset, < PERIOD.
REQ-007 Parameter SCROLL_STEP, default 1: rows moved per frame in scroll mode, 1..PERIOD-1.
REQ-008 clk  input  1  sole clock, all logic rising-edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 pixel_x  input  10  current pixel column.
REQ-011 pixel_y  input  10  current pixel row.
REQ-012 video_on  input  1  high during active video.
REQ-013 mode  input  2  00 off, 01 static dashed, 10 scrolling dashed, 11 solid.
REQ-014 pixel_on  output  1  registered net pixel.
REQ-015 frame_tick  output  1  one-cycle pulse at frame start.

Function
REQ-016 Net k (0..NUM_NETS-1) SHALL have centre C_k = H_VIDEO*(k+1)/(NUM_NETS+1), integer division, and cover columns C_k-NET_WIDTH/2 .. C_k+NET_WIDTH/2-1 inclusive.
REQ-017 Frame start SHALL be the cycle with video_on=1, pixel_x=0, pixel_y=0; line start SHALL be video_on=1, pixel_x=0, pixel_y!=0.
REQ-018 At frame start mode SHALL be latched into mode_q; mode changes mid-frame SHALL take effect only at the next frame start.
REQ-019 At frame start in mode_q=10, frame_phase SHALL update to (frame_phase - SCROLL_STEP) mod PERIOD (pattern moves down SCROLL_STEP rows/frame); other modes SHALL hold frame_phase.
REQ-020 Row value for row y SHALL equal (frame_phase_used + y) mod PERIOD, where frame_phase_used is the value in effect for that frame; row counter SHALL load it at frame start and increment with wrap PERIOD-1 -> 0 at each line start.
REQ-021 pixel_on SHALL be 1 one cycle after inputs iff video_on=1, pixel_x is within any net column, and: mode_q=01/10 and row value < DASH_HEIGHT; or mode_q=11.
REQ-022 pixel_on SHALL be 0 for mode_q=00, video_on=0, or outside all net columns.
REQ-023 With video_on=0 all counters and frame_phase SHALL hold.
REQ-024 frame_tick SHALL be 1 the cycle after each frame start, else 0.
REQ-025 Overlapping net columns (narrow H_VIDEO) SHALL OR together, no error.
REQ-026 Counter arithmetic SHALL be $clog2(PERIOD)-bit wide with explicit modulo, no unintended overflow.

Reset
REQ-027 rst=1 SHALL override all other inputs on the same edge.
REQ-028 After reset: pixel_on=0, frame_tick=0, mode_q=00, frame_phase=START_PHASE, row counter=START_PHASE.
REQ-029 Reset mid-frame SHALL blank output until the next frame start latches mode.

Structure
REQ-030 Mode encodings and H_VIDEO/V_VIDEO video constants SHALL live in the shared game definitions package; geometry parameters stay local.
REQ-031 The modulo row counter SHALL be one sub-module, dash_phase_counter (load, increment, wrap), instantiated once.

Verification
REQ-032 Defaults, mode=01, full frame -> column 317..322 lit on rows 6..17, 30..41; rows 0..5, 18..29 dark; columns 316, 323 never lit.
REQ-033 mode=10, SCROLL_STEP=1, three frames -> first lit row 7, 8, 9 in frames 2..4 (frame 1 row 6); wrap after 24 frames returns to row 6.
REQ-034 NUM_NETS=3, mode=11 -> columns 157..162, 317..322, 477..482 lit every active row, nothing else.
REQ-035 mode switched 01->00 at pixel_y=100 -> rest of frame unchanged, next frame fully dark; frame_tick pulses once per frame.
REQ-036 rst asserted at pixel_y=200 for 1 cycle -> pixel_on=0 next cycle and until next frame start; frame_phase=18 afterwards.
REQ-037 video_on=0 at pixel_x=0 during blanking rows -> row counter holds, pattern phase unchanged.
